// File: rtl/display_pkg.sv
// display_pkg: shared scan FSM encoding, default scanner sizing and anode helper.
package display_pkg;
  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_e;
  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_REFRESH_DIV = 1024;
  localparam int DEF_DRIVE_TICKS = 3;
  function automatic logic [31:0] anode_off(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
  endfunction
endpackage

// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if: value load side and multiplexed display outputs of the scanner.
interface seven_segment_scanner_if #(parameter int NUM_DIGITS = 4);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    value_load;
  logic [3:0]              digit_value;
  logic [NUM_DIGITS-1:0]   anode;
  logic [SW-1:0]           digit_sel;
  logic                    frame_done;
  logic                    load_pending;
  modport master (output value_in, value_load,
                  input  digit_value, anode, digit_sel, frame_done, load_pending);
  modport slave  (input  value_in, value_load,
                  output digit_value, anode, digit_sel, frame_done, load_pending);
endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider, tick high on the last cycle of each REFRESH_DIV period.
module scan_tick_gen #(
  parameter int REFRESH_DIV = 1024
) (
  input  logic clock_in,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(REFRESH_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == W'(REFRESH_DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge clock_in or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: blank/drive digit multiplexer with frame-aligned value updates.
// SCANNER_LEADING_ZERO_BLANK_EN keeps digits above the top nonzero nibble dark.
module seven_segment_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int DRIVE_TICKS = DEF_DRIVE_TICKS
) (
  input logic clock_in,
  input logic reset,
  seven_segment_scanner_if.slave bus
);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (DRIVE_TICKS > 1) ? $clog2(DRIVE_TICKS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  scan_state_e     state_q, state_d;
  logic [DW-1:0]   dt_q, dt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [VW-1:0]   disp_q, disp_d, pend_val_q, pend_val_d;
  logic [3:0]      dv_q, dv_d;
  logic            pend_q, pend_d, fd_q, fd_d;
  logic            tick, last, end_drive, bnd, lit;
  scan_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clock_in(clock_in),
    .reset   (reset),
    .tick    (tick)
  );
  assign last      = sel_q == SW'(NUM_DIGITS - 1);
  assign end_drive = tick && state_q == DRIVE && dt_q == DW'(DRIVE_TICKS - 1);
  assign bnd       = end_drive && last;
  always_comb begin
    state_d    = state_q;
    if (tick) state_d = (state_q == BLANK) ? DRIVE : (end_drive ? BLANK : DRIVE);
    dt_d       = (state_q == BLANK) ? '0 : (tick ? dt_q + DW'(1) : dt_q);
    sel_d      = end_drive ? (last ? '0 : sel_q + SW'(1)) : sel_q;
    fd_d       = bnd;
    pend_d     = bnd ? 1'b0 : (pend_q | bus.value_load);
    pend_val_d = (bus.value_load && !bnd) ? bus.value_in : pend_val_q;
    disp_d     = !bnd ? disp_q : (bus.value_load ? bus.value_in : (pend_q ? pend_val_q : disp_q));
    dv_d       = end_drive ? disp_d[{sel_d, 2'b00} +: 4] : dv_q;
  end
  always_ff @(posedge clock_in or posedge reset)
    if (reset) begin
      state_q    <= BLANK;
      dt_q       <= '0;
      sel_q      <= '0;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      fd_q       <= 1'b0;
      dv_q       <= '0;
    end else begin
      state_q    <= state_d;
      dt_q       <= dt_d;
      sel_q      <= sel_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      fd_q       <= fd_d;
      dv_q       <= dv_d;
    end
`ifdef SCANNER_LEADING_ZERO_BLANK_EN
  logic [SW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (disp_q[4*i +: 4] != 4'h0) msd = SW'(i);
  end
  assign lit = sel_q <= msd;
`else
  assign lit = 1'b1;
`endif
  assign bus.anode        = (state_q == DRIVE && lit) ? ~(NUM_DIGITS'(1) << sel_q)
                                                      : NUM_DIGITS'(anode_off(NUM_DIGITS));
  assign bus.digit_value  = dv_q;
  assign bus.digit_sel    = sel_q;
  assign bus.frame_done   = fd_q;
  assign bus.load_pending = pend_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: randomized and directed scan checks against a time-indexed display model.
module tb_seven_segment_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int t = 0;
  logic [15:0] disp = '0;
  logic [15:0] pend_val = '0;
  logic pend = 1'b0;
  seven_segment_scanner_if #(.NUM_DIGITS(4)) bus ();
  seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DRIVE_TICKS(3)) dut (
    .clock_in(clk),
    .reset   (rst),
    .bus     (bus)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_anode();
    int p, sel;
    logic lit;
    p = t % 64;
    sel = p / 16;
    lit = 1'b1;
`ifdef SCANNER_LEADING_ZERO_BLANK_EN
    for (int k = 3; k > 0; k--)
      if (k == sel && (disp >> (4 * sel)) == 16'h0) lit = 1'b0;
`endif
    return ((p % 16) < 4 || !lit) ? 4'hF : 4'hF ^ (4'b1 << sel);
  endfunction

  task automatic check_all();
    int sel;
    sel = (t % 64) / 16;
    check("anode", 32'(bus.anode), 32'(exp_anode()));
    check("one_hot_low", 32'($countones(~bus.anode) <= 1), 32'd1);
    check("digit_sel", 32'(bus.digit_sel), 32'(sel));
    check("digit_value", 32'(bus.digit_value), 32'((disp >> (4 * sel)) & 16'hF));
    check("frame_done", 32'(bus.frame_done), 32'(t > 0 && t % 64 == 0));
    check("load_pending", 32'(bus.load_pending), 32'(pend));
  endtask

  task automatic cyc(input logic ld, input logic [15:0] v);
    bus.value_load = ld;
    bus.value_in = v;
    @(posedge clk);
    t++;
    if (t % 64 == 0) begin
      disp = ld ? v : (pend ? pend_val : disp);
      pend = 1'b0;
    end else if (ld) begin
      pend_val = v;
      pend = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 64 && t % 64 != p; i++) cyc(1'b0, 16'h0);
  endtask

  task automatic model_reset();
    t = 0;
    disp = '0;
    pend_val = '0;
    pend = 1'b0;
  endtask

  initial begin
    bus.value_load = 1'b0;
    bus.value_in = '0;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    check_all();
    cyc(1'b1, 16'h1A2F);
    check("pend_after_load", 32'(bus.load_pending), 32'd1);
    repeat (140) cyc(1'b0, 16'h0);
    run_to(20);
    cyc(1'b1, 16'h1234);
    repeat (7) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h5678);
    repeat (100) cyc(1'b0, 16'h0);
    run_to(63);
    cyc(1'b1, 16'hBEEF);
    check("coincident_pend", 32'(bus.load_pending), 32'd0);
    repeat (70) cyc(1'b0, 16'h0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 19) == 0, 16'($urandom));
    run_to(40);
    bus.value_load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_anode", 32'(bus.anode), 32'hF);
    check("async_sel", 32'(bus.digit_sel), 32'd0);
    check("async_pend", 32'(bus.load_pending), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    repeat (80) cyc(1'b0, 16'h0);
    run_to(10);
    cyc(1'b1, 16'h0030);
    repeat (140) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h0000);
    repeat (140) cyc(1'b0, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
